// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side signals of the single-port memory arbiter.
// The slave modport is the arbiter's view; the master modport is the caches plus RAM.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: a requester raises its enable and holds address and data
    // stable. Its wait is low for exactly the one cycle the access completes.
    // Withdrawing the enable before that cycle cancels the access.
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              iwait;
    logic              dwait;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port arbiter between icache/dcache and unified RAM: data-first with a
// starvation guard for instruction fetch, plus a watchdog on stuck RAM accesses.
module memory_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                            CLK,
    input  logic                            nRST,
    memory_arbiter_if.slave                 bus,
    output logic                            err,
    output logic [1:0]                      dbg_state,
    output logic [$clog2(STARVE_MAX+1)-1:0] dbg_starve
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [WD_W-1:0] WD_LIM     = WD_W'(TIMEOUT);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [SC_W-1:0] starve_cnt, starve_n;
    logic [WD_W-1:0] wd_cnt, wd_n;
    logic            err_n;
    logic            d_req;
    logic            starve_force;

    assign d_req        = bus.dREN | bus.dWEN;
    assign starve_force = (starve_cnt == STARVE_LIM) && bus.iREN;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wd_cnt     <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            wd_cnt     <= wd_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        starve_n     = starve_cnt;
        wd_n         = wd_cnt;
        err_n        = err;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;

        case (state)
            IDLE: begin
                if (d_req && !starve_force) begin
                    state_n = GNT_D;
                    wd_n    = '0;
                end else if (bus.iREN) begin
                    state_n = GNT_I;
                    wd_n    = '0;
                end
            end

            GNT_D: begin
                // Write wins when a cache raises both enables.
                bus.ramaddr  = bus.daddr;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramstore = bus.dstore;
                if (!d_req) begin
                    state_n = IDLE;
                end else if (bus.ramstate == RAM_ERROR || wd_cnt == WD_LIM) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    bus.dwait = 1'b0;
                    state_n   = IDLE;
                    if (!bus.iREN)
                        starve_n = '0;
                    else if (starve_cnt != STARVE_LIM)
                        starve_n = starve_cnt + 1'b1;
                end else begin
                    wd_n = wd_cnt + 1'b1;
                end
            end

            GNT_I: begin
                // Enable follows iREN so a withdrawal drops it the same cycle.
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    state_n = IDLE;
                end else if (bus.ramstate == RAM_ERROR || wd_cnt == WD_LIM) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    bus.iwait = 1'b0;
                    state_n   = IDLE;
                    starve_n  = '0;
                end else begin
                    wd_n = wd_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Load data is a straight passthrough; each cache qualifies it with its wait.
    assign bus.iload  = bus.ramload;
    assign bus.dload  = bus.ramload;
    assign dbg_state  = state;
    assign dbg_starve = starve_cnt;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a RAM responder, an expected-response
// queue checked by a monitor on every wait pulse, and direct cycle checks.
module tb_memory_arbiter;
    localparam int W = 66;
    localparam int RAM_NORMAL = 0;
    localparam int RAM_HANG   = 1;
    localparam int RAM_ERR    = 2;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       err;
    logic [1:0] dbg_state;
    logic [2:0] dbg_starve;

    int n_checks = 0;
    int n_fail   = 0;
    int ram_mode = RAM_NORMAL;
    int ram_cnt  = 0;

    logic [31:0]  mem [0:255];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act;

    always #5 CLK = ~CLK;

    memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    memory_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(255)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus),
        .err(err),
        .dbg_state(dbg_state),
        .dbg_starve(dbg_starve)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    task automatic wait_low(input bit is_d, input string name);
        int  k = 0;
        bit  done = 1'b0;
        while (!done && k < 50) begin
            @(negedge CLK);
            if (is_d ? !bus.dwait : !bus.iwait) done = 1'b1;
            k++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: wait still high after %0d cycles, required low", name, k);
        end
    endtask

    // RAM responder: ACCESS on the 2nd enabled cycle in normal mode.
    initial begin
        bus.ramstate = 2'd0;
        bus.ramload  = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[16] = 32'hDEADBEEF;
        forever begin
            @(posedge CLK);
            #2;
            if (nRST && (bus.ramREN || bus.ramWEN)) begin
                ram_cnt++;
                case (ram_mode)
                    RAM_NORMAL: begin
                        if (ram_cnt >= 2) begin
                            bus.ramstate = 2'd2;
                            if (bus.ramWEN) mem[bus.ramaddr[9:2]] = bus.ramstore;
                        end else begin
                            bus.ramstate = 2'd1;
                        end
                    end
                    RAM_HANG: bus.ramstate = 2'd1;
                    default:  bus.ramstate = 2'd3;
                endcase
            end else begin
                ram_cnt      = 0;
                bus.ramstate = 2'd0;
            end
            bus.ramload = mem[bus.ramaddr[9:2]];
        end
    end

    // Monitor: every wait pulse must match the next expected response.
    always @(negedge CLK) begin
        if (!bus.iwait && !bus.dwait) begin
            n_checks++;
            n_fail++;
            $display("FAIL both_waits: got iwait=0 dwait=0, required at most one low");
        end else if (!bus.iwait || !bus.dwait) begin
            mon_act = {!bus.dwait, bus.ramWEN, bus.ramaddr,
                       bus.ramWEN ? bus.ramstore : (!bus.dwait ? bus.dload : bus.iload)};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got %0h with empty expected queue", mon_act);
            end else begin
                chk("scoreboard", mon_act, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        int gcnt;
        int done_n;
        int k;
        bit hit;
        nRST = 1'b0;
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        repeat (3) tick();
        nRST = 1'b1;
        at_neg();
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 1);
        chk("rst_err", err, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_starve", dbg_starve, 0);

        // Instruction read with the two-cycle minimum access.
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        exp_q.push_back({1'b0, 1'b0, 32'h40, 32'hDEADBEEF});
        at_neg(); chk("t1_no_en_c0", bus.ramREN, 0);
        tick(); at_neg();
        chk("t1_ren_c1", bus.ramREN, 1);
        chk("t1_iwait_c1", bus.iwait, 1);
        chk("t1_addr_c1", bus.ramaddr, 32'h40);
        tick(); at_neg();
        chk("t1_ren_c2", bus.ramREN, 1);
        chk("t1_iwait_c2", bus.iwait, 0);
        tick(); bus.iREN = 1'b0; at_neg();
        chk("t1_iwait_c3", bus.iwait, 1);
        chk("t1_state_c3", dbg_state, 0);

        // Simultaneous D write and I read: data first, then I after an idle cycle.
        tick();
        bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678;
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        exp_q.push_back({1'b1, 1'b1, 32'h80, 32'h12345678});
        exp_q.push_back({1'b0, 1'b0, 32'h44, 32'hC0DE0011});
        at_neg(); chk("t2_state_c0", dbg_state, 0);
        tick(); at_neg();
        chk("t2_state_c1", dbg_state, 1);
        chk("t2_wen_c1", bus.ramWEN, 1);
        chk("t2_ren_c1", bus.ramREN, 0);
        chk("t2_addr_c1", bus.ramaddr, 32'h80);
        chk("t2_store_c1", bus.ramstore, 32'h12345678);
        wait_low(1'b1, "t2_dwait");
        tick(); bus.dWEN = 1'b0; at_neg();
        chk("t2_gap_state", dbg_state, 0);
        chk("t2_gap_ren", bus.ramREN, 0);
        chk("t2_starve_1", dbg_starve, 1);
        tick(); at_neg();
        chk("t2_state_i", dbg_state, 2);
        chk("t2_addr_i", bus.ramaddr, 32'h44);
        wait_low(1'b0, "t2_iwait");
        tick(); bus.iREN = 1'b0; at_neg();
        chk("t2_starve_clr", dbg_starve, 0);

        // Starvation guard: four D grants, then one I, then D again.
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h88;
        bus.iREN = 1'b1; bus.iaddr = 32'h48;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 1'b0, 32'h88, 32'hC0DE0022});
        exp_q.push_back({1'b0, 1'b0, 32'h48, 32'hC0DE0012});
        exp_q.push_back({1'b1, 1'b0, 32'h88, 32'hC0DE0022});
        done_n = 0; k = 0;
        while (done_n < 6 && k < 100) begin
            @(negedge CLK);
            if (!bus.dwait || !bus.iwait) done_n++;
            k++;
        end
        chk("t3_completions", done_n, 6);
        tick(); bus.dREN = 1'b0; bus.iREN = 1'b0; at_neg();
        chk("t3_starve_after", dbg_starve, 1);
        chk("t3_state_idle", dbg_state, 0);

        // Both D enables: write wins.
        tick();
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h8C; bus.dstore = 32'hA5A5A5A5;
        exp_q.push_back({1'b1, 1'b1, 32'h8C, 32'hA5A5A5A5});
        at_neg(); tick(); at_neg();
        chk("t4_wen", bus.ramWEN, 1);
        chk("t4_ren", bus.ramREN, 0);
        wait_low(1'b1, "t4_dwait");

        // I withdrawn while RAM is BUSY.
        tick();
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
        ram_mode = RAM_HANG;
        bus.iREN = 1'b1; bus.iaddr = 32'h50;
        at_neg(); tick(); at_neg();
        chk("t4b_ren_busy", bus.ramREN, 1);
        tick(); bus.iREN = 1'b0; at_neg();
        chk("t4b_ren_drop", bus.ramREN, 0);
        chk("t4b_iwait", bus.iwait, 1);
        chk("t4b_state_gnt", dbg_state, 2);
        tick(); at_neg();
        chk("t4b_state_idle", dbg_state, 0);
        chk("t4b_err", err, 0);

        // Watchdog: 256 BUSY cycles in GNT_D raise err with no wait pulse.
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h90;
        gcnt = 0; k = 0; hit = 1'b0;
        while (!hit && k < 400) begin
            @(negedge CLK);
            if (err) hit = 1'b1;
            else if (dbg_state == 2'd1) gcnt++;
            k++;
        end
        chk("t5_wd_cycles", gcnt, 256);
        chk("t5_wd_err", err, 1);
        chk("t5_wd_state", dbg_state, 0);
        tick(); bus.dREN = 1'b0;
        tick(); at_neg();
        chk("t5_wd_settle", dbg_state, 0);

        // RAM ERROR: err one edge later, clears only on reset.
        nRST = 1'b0;
        tick(); nRST = 1'b1; ram_mode = RAM_ERR;
        at_neg(); chk("t5b_err_rst", err, 0);
        tick(); bus.dREN = 1'b1; bus.daddr = 32'h94;
        at_neg(); tick(); at_neg();
        chk("t5b_state_gnt", dbg_state, 1);
        chk("t5b_err_pre", err, 0);
        chk("t5b_dwait", bus.dwait, 1);
        tick(); at_neg();
        chk("t5b_err_set", err, 1);
        chk("t5b_state_idle", dbg_state, 0);
        tick(); bus.dREN = 1'b0;
        tick(); ram_mode = RAM_NORMAL;

        // Leave starve_cnt at 1, then reset in the middle of a BUSY write.
        bus.dREN = 1'b1; bus.daddr = 32'h9C;
        bus.iREN = 1'b1; bus.iaddr = 32'h54;
        exp_q.push_back({1'b1, 1'b0, 32'h9C, 32'hC0DE0027});
        wait_low(1'b1, "t6_pre_dwait");
        tick(); bus.dREN = 1'b0; bus.iREN = 1'b0; at_neg();
        chk("t6_pre_starve", dbg_starve, 1);
        ram_mode = RAM_HANG;
        tick(); bus.dWEN = 1'b1; bus.daddr = 32'h98; bus.dstore = 32'h5555AAAA;
        at_neg(); tick(); at_neg();
        chk("t6_wen_busy", bus.ramWEN, 1);
        tick(); nRST = 1'b0;
        tick(); at_neg();
        chk("t6_ren", bus.ramREN, 0);
        chk("t6_wen", bus.ramWEN, 0);
        chk("t6_dwait", bus.dwait, 1);
        chk("t6_err", err, 0);
        chk("t6_starve", dbg_starve, 0);
        chk("t6_state", dbg_state, 0);
        tick(); bus.dWEN = 1'b0; nRST = 1'b1;
        repeat (3) tick();
        chk("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
